// File: rtl/nco_freq_meter.sv
// Measures the period of an external square wave over 2^NPER_LOG2 cycles and
// converts it into an NCO tuning word: floor(2^(SIZE+NPER_LOG2) / P), saturated.
module nco_freq_meter #(
   parameter int SIZE      = 26,
   parameter int CNT_W     = 24,
   parameter int NPER_LOG2 = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            sig_in_i,
   input  logic            enable_i,
   output logic [SIZE-1:0] freq_word_o,
   output logic            valid_o,
   output logic            overflow_o,
   output logic            busy_o
);

   localparam int QW  = SIZE + NPER_LOG2 + 1;
   localparam int DCW = $clog2(QW);
   localparam int ECW = NPER_LOG2 + 1;
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [ECW-1:0]   LAST_EDGE = ECW'((1 << NPER_LOG2) - 1);
   localparam logic [DCW-1:0]   LAST_STEP = DCW'(QW - 1);

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      MEASURE,
      DIVIDE,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic             sync1_q, sync2_q, sync3_q;
   logic             edgePulse;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ECW-1:0]   edgeCnt_q, edgeCnt_d;
   logic [CNT_W:0]   period_q, period_d;
   logic [CNT_W:0]   rem_q, rem_d;
   logic [QW-2:0]    quot_q, quot_d;
   logic [DCW-1:0]   step_q, step_d;
   logic [SIZE-1:0]  freqWord_q, freqWord_d;
   logic             valid_q, valid_d;
   logic             overflow_q, overflow_d;

   logic [CNT_W+1:0] trialRem;
   logic [CNT_W+1:0] trialDiff;
   logic             fits;
   logic [QW-1:0]    quotNext;

   assign edgePulse = sync2_q & ~sync3_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      edgeCnt_d  = edgeCnt_q;
      period_d   = period_q;
      rem_d      = rem_q;
      quot_d     = quot_q;
      step_d     = step_q;
      freqWord_d = freqWord_q;
      valid_d    = 1'b0;
      overflow_d = overflow_q;

      // The numerator is a single 1 followed by zeros, so only step 0 shifts in a one.
      trialRem  = {rem_q, (step_q == '0)};
      trialDiff = trialRem - {1'b0, period_q};
      fits      = ~trialDiff[CNT_W+1];
      quotNext  = {quot_q, fits};

      if (!enable_i) begin
         state_d    = IDLE;
         cnt_d      = '0;
         overflow_d = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               cnt_d   = '0;
               state_d = ARM;
            end
            ARM: begin
               if (edgePulse) begin
                  cnt_d     = '0;
                  edgeCnt_d = '0;
                  state_d   = MEASURE;
               end else if (cnt_q == CNT_MAX) begin
                  freqWord_d = '0;
                  overflow_d = 1'b1;
                  valid_d    = 1'b1;
                  cnt_d      = '0;
                  state_d    = DONE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            MEASURE: begin
               if (edgePulse) begin
                  if (edgeCnt_q == LAST_EDGE) begin
                     period_d = {1'b0, cnt_q} + 1'b1;
                     rem_d    = '0;
                     quot_d   = '0;
                     step_d   = '0;
                     state_d  = DIVIDE;
                  end else begin
                     edgeCnt_d = edgeCnt_q + 1'b1;
                     cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                  end
               end else if (cnt_q == CNT_MAX) begin
                  freqWord_d = '0;
                  overflow_d = 1'b1;
                  valid_d    = 1'b1;
                  cnt_d      = '0;
                  state_d    = DONE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            DIVIDE: begin
               rem_d  = fits ? trialDiff[CNT_W:0] : trialRem[CNT_W:0];
               quot_d = quotNext[QW-2:0];
               step_d = step_q + 1'b1;
               if (step_q == LAST_STEP) begin
                  freqWord_d = (|quotNext[QW-1:SIZE]) ? '1 : quotNext[SIZE-1:0];
                  valid_d    = 1'b1;
                  overflow_d = 1'b0;
                  state_d    = DONE;
               end
            end
            DONE: begin
               cnt_d   = '0;
               state_d = ARM;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         sync3_q    <= 1'b0;
         cnt_q      <= '0;
         edgeCnt_q  <= '0;
         period_q   <= '0;
         rem_q      <= '0;
         quot_q     <= '0;
         step_q     <= '0;
         freqWord_q <= '0;
         valid_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sync1_q    <= sig_in_i;
         sync2_q    <= sync1_q;
         sync3_q    <= sync2_q;
         cnt_q      <= cnt_d;
         edgeCnt_q  <= edgeCnt_d;
         period_q   <= period_d;
         rem_q      <= rem_d;
         quot_q     <= quot_d;
         step_q     <= step_d;
         freqWord_q <= freqWord_d;
         valid_q    <= valid_d;
         overflow_q <= overflow_d;
      end
   end

   assign freq_word_o = freqWord_q;
   assign valid_o     = valid_q;
   assign overflow_o  = overflow_q;
   assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_nco_freq_meter.sv
// Scoreboard bench for nco_freq_meter: expected words are queued as each burst
// of input edges is driven and compared whenever the meter pulses valid.
module tb_nco_freq_meter;

   localparam int SIZE      = 26;
   localparam int CNT_W     = 14;
   localparam int NPER_LOG2 = 2;
   // Input rise in cycle k -> edge pulse in k+2 -> valid in k+2+Q+1.
   localparam int RISE_TO_VALID = 2 + (SIZE + NPER_LOG2 + 1) + 1;

   typedef struct {
      logic [31:0] word;
      logic        ovf;
      int          cyc;
   } exp_t;

   logic            clk = 1'b0;
   logic            reset;
   logic            sigIn;
   logic            enable;
   logic [SIZE-1:0] freqWord;
   logic            valid;
   logic            overflow;
   logic            busy;

   int          checks = 0;
   int          failures = 0;
   int          cycleCnt = 0;
   int          lastRise = 0;
   logic [31:0] lastWord = 0;
   exp_t        sbQ[$];

   nco_freq_meter #(
      .SIZE(SIZE),
      .CNT_W(CNT_W),
      .NPER_LOG2(NPER_LOG2)
   ) dut (
      .clk(clk),
      .reset(reset),
      .sig_in_i(sigIn),
      .enable_i(enable),
      .freq_word_o(freqWord),
      .valid_o(valid),
      .overflow_o(overflow),
      .busy_o(busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cycleCnt <= cycleCnt + 1;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cycleCnt);
      end
   endtask

   // Drive nRises rising edges spaced by period clocks; the final pulse is one clock wide.
   task automatic applyStimulus(input int period, input int nRises, input bit jitter);
      int hi;
      int off;
      hi = period / 2;
      for (int r = 0; r < nRises; r++) begin
         @(posedge clk);
         off = jitter ? int'($urandom_range(8, 1)) : 1;
         #off;
         sigIn    = 1'b1;
         lastRise = cycleCnt;
         if (r == nRises - 1) begin
            @(posedge clk);
            #1;
            sigIn = 1'b0;
         end else begin
            repeat (hi) @(posedge clk);
            off = jitter ? int'($urandom_range(8, 1)) : 1;
            #off;
            sigIn = 1'b0;
            repeat (period - hi - 1) @(posedge clk);
         end
      end
   endtask

   task automatic expectWord(input logic [31:0] word, input logic ovf, input int cyc);
      exp_t e;
      e.word = word;
      e.ovf  = ovf;
      e.cyc  = cyc;
      sbQ.push_back(e);
   endtask

   task automatic waitDrain(input int budget);
      int n;
      n = 0;
      while (sbQ.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      if (sbQ.size() != 0) begin
         checkOutput("drain_timeout", sbQ.size(), 0);
         sbQ.delete();
      end
      repeat (4) @(posedge clk);
   endtask

   task automatic measure(input int period, input bit jitter, input logic [31:0] word);
      applyStimulus(period, 5, jitter);
      expectWord(word, 1'b0, lastRise + RISE_TO_VALID);
      waitDrain(200);
   endtask

   always @(negedge clk) begin
      if (valid === 1'b1) begin
         if (sbQ.size() == 0) begin
            checkOutput("unexpected_valid", valid, 0);
         end else begin
            exp_t e;
            e = sbQ.pop_front();
            checkOutput("freq_word", freqWord, e.word);
            checkOutput("overflow", overflow, e.ovf);
            if (e.cyc >= 0) checkOutput("latency", cycleCnt, e.cyc);
            lastWord = e.word;
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset  = 1'b1;
      sigIn  = 1'b0;
      enable = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_freq_word", freqWord, 0);
      checkOutput("reset_valid", valid, 0);
      checkOutput("reset_overflow", overflow, 0);
      checkOutput("reset_busy", busy, 0);
      @(posedge clk);
      #1;
      reset  = 1'b0;
      enable = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      checkOutput("armed_busy", busy, 1);

      $display("[TB] 384-clk period");
      measure(384, 1'b0, 32'd174762);

      $display("[TB] 2-clk period (fastest input)");
      measure(2, 1'b0, 32'd33554432);

      $display("[TB] 384 -> 1536 period change with edge jitter");
      measure(384, 1'b1, 32'd174762);
      measure(1536, 1'b1, 32'd43690);

      $display("[TB] enable dropped during MEASURE");
      applyStimulus(384, 2, 1'b0);
      enable = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("abort_meas_busy", busy, 0);
      checkOutput("abort_meas_word", freqWord, lastWord);
      repeat (40) @(posedge clk);
      #1;
      enable = 1'b1;
      repeat (3) @(posedge clk);
      measure(384, 1'b0, 32'd174762);

      $display("[TB] enable dropped during DIVIDE");
      applyStimulus(1536, 5, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      enable = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("abort_div_busy", busy, 0);
      checkOutput("abort_div_word", freqWord, lastWord);
      repeat (60) @(posedge clk);
      #1;
      enable = 1'b1;
      repeat (3) @(posedge clk);
      measure(384, 1'b0, 32'd174762);

      $display("[TB] reset during DIVIDE");
      applyStimulus(1536, 5, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      lastWord = 0;
      checkOutput("rst_div_word", freqWord, 0);
      checkOutput("rst_div_valid", valid, 0);
      checkOutput("rst_div_overflow", overflow, 0);
      checkOutput("rst_div_busy", busy, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (60) @(posedge clk);
      measure(384, 1'b0, 32'd174762);

      $display("[TB] timeout then recovery");
      expectWord(32'd0, 1'b1, -1);
      waitDrain(17000);
      @(negedge clk);
      checkOutput("overflow_sticky", overflow, 1);
      checkOutput("timeout_word_held", freqWord, 0);
      measure(384, 1'b0, 32'd174762);

      $display("[TB] timeout then enable low clears overflow");
      expectWord(32'd0, 1'b1, -1);
      waitDrain(17000);
      #1;
      enable = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("ovf_clear_on_disable", overflow, 0);
      checkOutput("disable_busy", busy, 0);
      checkOutput("disable_word_held", freqWord, lastWord);
      repeat (20) @(posedge clk);
      @(negedge clk);
      checkOutput("idle_overflow", overflow, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
